// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one multi-cycle divider core
// among N_REQ requesters; divide-by-zero is answered locally.
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_quotient,
  output logic [WIDTH-1:0]       rsp_remainder,
  output logic                   rsp_dbz,
  output logic                   rsp_err,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic                   div_done,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     g_q, g_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [2*N_REQ-1:0] dbl;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;
  logic [IW-1:0]      grant;
  logic               grant_vld;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Rotate requests so bit 0 is rr_q, then take the first set bit.
  always_comb begin
    dbl       = {req_valid, req_valid} >> rr_q;
    off       = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && dbl[k]) begin
        grant_vld = 1'b1;
        off       = IW'(k);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) begin
      grant = IW'(sum - (IW+1)'(N_REQ));
    end else begin
      grant = IW'(sum);
    end
    sel_a = req_dividend[grant*WIDTH +: WIDTH];
    sel_b = req_divisor[grant*WIDTH +: WIDTH];
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld && !rst) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      rsp_valid[g_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          g_d   = grant;
          opa_d = sel_a;
          opb_d = sel_b;
          if (sel_b == '0) begin
            quo_d   = '1;
            rem_d   = sel_a;
            dbz_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (div_done) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          state_d = RESP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[g_q]) begin
          if (g_q == IW'(N_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = g_q + IW'(1);
          end
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_start     = (state_q == ISSUE);
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: random requesters, a latency
// model of the divider core, and a round-robin reference model.
module tb_div_arbiter;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int TO   = 12;
  localparam int HANG = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_dividend, req_divisor;
  logic [N-1:0]     rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_quotient, rsp_remainder;
  logic             rsp_dbz, rsp_err;
  logic             div_start, div_done;
  logic [W-1:0]     div_dividend, div_divisor;
  logic [W-1:0]     div_quotient, div_remainder;

  div_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
    .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dbz;
    logic       err;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cyc = 0;
  int   force_lat = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model and monitor
  int           rr = 0;
  int           g;
  int           start_due = -1;
  int           exp_c;
  bit           busy = 0, prev_rv = 0, post_rst = 0;
  logic [W-1:0] ea, eb;
  logic [N-1:0] eg;
  logic [69:0]  prev_b;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      rr = 0; busy = 0; prev_rv = 0;
      start_due = -1; post_rst = 1;
    end else begin
      if (post_rst) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_quotient", rsp_quotient, 0);
        chk("rst_remainder", rsp_remainder, 0);
        chk("rst_flags", {rsp_dbz, rsp_err}, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_ops", {div_dividend, div_divisor}, 0);
        post_rst = 0;
      end
      if (busy) begin
        chk("req_ready_busy", req_ready, 0);
      end else begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", req_ready, eg);
        if (g >= 0 && req_ready[g]) begin
          ea = req_dividend[g*W +: W];
          eb = req_divisor[g*W +: W];
          e.idx = g;
          e.acc = cyc;
          e.dbz = (eb == 0);
          e.err = (eb == HANG);
          e.q = e.dbz ? '1 : e.err ? '0 : ea / eb;
          e.r = e.dbz ? ea : e.err ? '0 : ea % eb;
          sb.push_back(e);
          busy = 1;
          start_due = e.dbz ? -1 : cyc + 1;
        end
      end
      chk("div_start", div_start, cyc == start_due);
      if (div_start) chk("start_ops", {div_dividend, div_divisor}, {ea, eb});
      if (rsp_valid != 0) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", rsp_valid, 0);
          prev_rv = 0;
        end else begin
          e = sb[0];
          if (!prev_rv) begin
            exp_c = e.dbz ? e.acc + 1 :
                    e.err ? e.acc + 1 + TO : done_cyc + 1;
            chk("rsp_latency", cyc, exp_c);
            eg = '0; eg[e.idx] = 1'b1;
            chk("rsp_idx", rsp_valid, eg);
            chk("rsp_quotient", rsp_quotient, e.q);
            chk("rsp_remainder", rsp_remainder, e.r);
            chk("rsp_dbz_err", {rsp_dbz, rsp_err}, {e.dbz, e.err});
          end else begin
            chk("rsp_stable",
                {rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err},
                prev_b);
          end
          prev_b = {rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err};
          prev_rv = 1;
          if (rsp_ready[e.idx]) begin
            void'(sb.pop_front());
            busy = 0;
            prev_rv = 0;
            rr = (e.idx + 1) % N;
          end
        end
      end else begin
        prev_rv = 0;
      end
    end
  end

  // Divider core model; divisor HANG never completes on time and
  // then strobes a late done once the response is up.
  initial begin
    logic [W-1:0] a, b;
    int lat;
    div_done = 0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      if (div_start && !rst) begin
        a = div_dividend;
        b = div_divisor;
        if (b == HANG) begin
          for (int i = 0; i < 60 && rsp_valid == 0; i++) @(negedge clk);
          @(posedge clk); #1;
          div_done = 1;
          div_quotient = $urandom;
          div_remainder = $urandom;
          @(posedge clk); #1;
          div_done = 0;
        end else begin
          lat = (force_lat != 0) ? force_lat : $urandom_range(1, TO - 1);
          repeat (lat) @(posedge clk);
          #1;
          div_done = 1;
          div_quotient = a / b;
          div_remainder = a % b;
          done_cyc = cyc;
          @(posedge clk); #1;
          div_done = 0;
          div_quotient = $urandom;
          div_remainder = $urandom;
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  function automatic logic [W-1:0] rnd_b();
    int s;
    logic [W-1:0] v;
    s = $urandom_range(0, 15);
    if (s == 0) v = '0;
    else if (s == 1) v = HANG;
    else if (s == 2) v = 1;
    else if (s == 3) v = '1;
    else if (s < 8) v = $urandom_range(2, 50);
    else v = $urandom;
    if (s > 3 && (v == 0 || v == HANG)) v = 7;
    return v;
  endfunction

  task automatic cycle_drv(input bit rnd);
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~hs;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, ($urandom_range(0, 1) == 1) ? $urandom
                                               : $urandom_range(0, 100),
                 rnd_b());
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = N'($urandom);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && (sb.size() != 0 || req_valid != 0); c++)
      cycle_drv(0);
    if (sb.size() != 0 || req_valid != 0) begin
      $display("FAIL drain: %0d responses still pending", sb.size());
      $fatal(1);
    end
  endtask

  task automatic do_req(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    set_op(i, a, b);
    req_valid[i] = 1'b1;
  endtask

  initial begin
    rst = 1; req_valid = '0; rsp_ready = '0;
    req_dividend = '0; req_divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rsp_ready = '1;

    do_req(0, 100, 7);
    drain();

    for (int i = 0; i < N; i++) set_op(i, 20, 3);
    for (int c = 0; c < 80; c++) begin
      cycle_drv(0);
      req_valid = (c == 79) ? '0 : '1;
    end
    drain();

    do_req(2, 55, 0);
    drain();

    force_lat = TO - 1;
    do_req(3, 1000, 9);
    drain();
    force_lat = 1;
    do_req(0, 5, 9);
    drain();
    force_lat = 0;

    rsp_ready = '0;
    do_req(1, 77, HANG);
    for (int c = 0; c < 40 && rsp_valid == 0; c++) cycle_drv(0);
    if (rsp_valid == 0) begin
      $display("FAIL timeout_rsp: rsp_valid 0, expected a response");
      $fatal(1);
    end
    do_req(0, 30, 4);
    repeat (5) cycle_drv(0);
    rsp_ready = '1;
    drain();

    for (int c = 0; c < 2500; c++) cycle_drv(1);
    req_valid = '0;
    rsp_ready = '1;
    drain();

    do_req(3, 9, HANG);
    repeat (4) cycle_drv(0);
    rst = 1;
    cycle_drv(0);
    rst = 0;
    repeat (70) cycle_drv(0);
    for (int i = 0; i < N; i++) set_op(i, 40 + i, 6);
    req_valid = '1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, sim not finished");
    $fatal(1);
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle divider core among `N_REQ` requesters. It accepts a divide request from one requester at a time and issues it to the core with a one-cycle start pulse. It waits for the core's done strobe, or for a watchdog timeout, and returns quotient and remainder to the originating requester over a valid/ready handshake. Divide-by-zero is resolved locally without occupying the core.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits
- `N_REQ`, 4, number of requesters (2..16)
- `TIMEOUT`, 64, maximum cycles in WAIT before abort (≥ 2)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept; at most one bit set
- `req_dividend`  in  N_REQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
- `req_divisor`  in  N_REQ*WIDTH  packed divisors, same packing
- `rsp_valid`  out  N_REQ  per-requester response valid; at most one bit set
- `rsp_ready`  in  N_REQ  per-requester response accept
- `rsp_quotient`  out  WIDTH  shared response quotient
- `rsp_remainder`  out  WIDTH  shared response remainder
- `rsp_dbz`  out  1  response is divide-by-zero
- `rsp_err`  out  1  response is timeout abort
- `div_start`  out  1  one-cycle start pulse to core
- `div_dividend`, `div_divisor`  out  WIDTH each  operands to core, held stable from start until done
- `div_done`  in  1  core completion strobe
- `div_quotient`, `div_remainder`  in  WIDTH each  core results, valid with `div_done`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant `g` = first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready[g]`=1 combinationally; no grant when no request.
  - On handshake, latch `g`, dividend and divisor.
  - Divisor ≠ 0 → ISSUE.
  - Divisor = 0 → RESP with quotient = all ones, remainder = dividend, `rsp_dbz`=1.
- ISSUE: `div_start`=1 for exactly this cycle; clear timeout counter; → WAIT.
- WAIT:
  - Counter increments each cycle.
  - `div_done`=1 → latch `div_quotient`/`div_remainder`, → RESP.
  - Counter reaches TIMEOUT-1 without done → RESP with quotient=0, remainder=0, `rsp_err`=1.
  - `div_done` and timeout in the same cycle: done wins.
- RESP:
  - `rsp_valid[g]`=1 with stable data until `rsp_ready[g]`.
  - On handshake: `rr_ptr` ← (g+1) mod N_REQ, clear dbz/err, → IDLE.
  - `rsp_ready` on other indices is ignored.
- `div_done` outside WAIT is ignored and causes no state change.
- `req_ready` is all zeros outside IDLE; requesters hold `req_valid` and operands until accepted.
- `rr_ptr` advances only on response completion, so a requester that is kept waiting cannot be starved: worst-case wait is N_REQ-1 full transactions.
- Reset: all outputs 0, `rr_ptr`=0, FSM=IDLE. Reset in any state aborts the transaction with no response; a core still busy is ignored and its later `div_done` is dropped.

## Timing
- Request accepted at cycle T:
  - `div_start` at T+1.
  - `div_done` seen at cycle D → `rsp_valid` at D+1.
  - Divide-by-zero → `rsp_valid` at T+1, no `div_start`.
  - Timeout → `rsp_valid` at T+1+TIMEOUT.
- Response accepted at cycle R → IDLE at R+1; next `req_ready` is possible at R+1.
- Minimum back-to-back throughput: one transaction per (core latency + 3) cycles.
- `div_dividend`/`div_divisor` are registered and change only on request accept.

## Test plan
- Single request: req0 100/7, core done after 10 cycles → `div_start` at T+1, `rsp_valid[0]` with q=14, r=2, dbz=0, err=0.
- Round-robin: req0..req3 all valid continuously with 20/3 each → grants in order 0,1,2,3,0; never two `req_ready` bits set; each response q=6, r=2.
- Divide-by-zero: req2 55/0 → `rsp_valid[2]` at T+1, q=0xFFFFFFFF, r=55, dbz=1; `div_start` never asserts.
- Timeout: TIMEOUT=8, core never asserts done → `rsp_err`=1, q=0, r=0 at T+9. A late `div_done` after this is ignored.
- Backpressure: hold `rsp_ready[1]`=0 for 5 cycles → `rsp_valid[1]` and data stable throughout, no new `req_ready`; release → IDLE next cycle.
- Reset mid-WAIT: assert `rst` for 1 cycle → all outputs 0, `rr_ptr`=0, and a subsequent stray `div_done` produces no response.
